fp_mult_scheduler: RTL and testbench
====================================

Name: fp_mult_scheduler

Overview:
Shares one pipelined floating point multiplier among N_REQ requesters. Each cycle it grants at most one pending request using round-robin arbitration and registers the operands into the multiplier's input port. It carries the requester ID through a tag pipeline matched to the multiplier latency, then steers each returning product back to the requester that issued it. It sits between the requesting compute units and the multiplier instance, which it drives through its mul_* ports.

Parameters:
EXP_WIDTH, 8, exponent bits of the FP format
FRAC_WIDTH, 23, fraction bits of the FP format
N_REQ, 4, number of requesters (>=2)
MULT_LATENCY, 2, cycles from mul_valid_o high to mul_valid_i high for the same op
FP_WIDTH (local), 1+EXP_WIDTH+FRAC_WIDTH
ID_WIDTH (local), $clog2(N_REQ)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  when low no new grants are issued; in-flight ops still complete
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept (one-hot or zero)
req_a_i  in  N_REQ*FP_WIDTH  operand A, requester i at slice i
req_b_i  in  N_REQ*FP_WIDTH  operand B, requester i at slice i
mul_a_o  out  FP_WIDTH  operand A to multiplier
mul_b_o  out  FP_WIDTH  operand B to multiplier
mul_valid_o  out  1  operand valid to multiplier
mul_fp_i  in  FP_WIDTH  product from multiplier
mul_valid_i  in  1  product valid from multiplier
res_valid_o  out  N_REQ  one-hot result strobe to the owning requester
res_fp_o  out  FP_WIDTH  result value, shared by all requesters
busy_o  out  1  an op is issued or in flight
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high): rr_ptr=0, issue register cleared, all tag stages invalid, err_o=0. While reset is asserted, all outputs read 0: mul_valid_o, res_valid_o, busy_o, err_o, req_ready_o, mul_a_o, mul_b_o, res_fp_o.
- Arbitration (combinational):
  - Candidate set = req_valid_i when enable_i=1, otherwise empty.
  - Grant goes to the first set bit scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - req_ready_o = grant, so it is one-hot or zero. Ready never depends on ready of another requester.
- Accept: a transfer happens when req_valid_i[i] & req_ready_o[i].
  - On that edge: mul_a_o/mul_b_o <= slice i, mul_valid_o <= 1, issue_id <= i, rr_ptr <= (i+1) mod N_REQ.
  - Cycle with no transfer: mul_valid_o <= 0, rr_ptr holds, operand registers hold.
  - Throughput: one op per cycle.
  - Requesters must hold valid and data stable until accepted.
- Tag pipeline:
  - Shift register of MULT_LATENCY stages of {valid, id}.
  - Stage 0 loads {mul_valid_o, issue_id} each cycle; it shifts every cycle with no stall.
  - The last stage aligns with mul_valid_i.
- Return (combinational):
  - When mul_valid_i=1 and the last tag is valid: res_valid_o = onehot(last tag id), res_fp_o = mul_fp_i.
  - res_fp_o = 0 when no result is returned.
  - There is no backpressure on the result channel; requesters must accept results on any cycle.
- Errors:
  - mul_valid_i=1 with the last tag invalid: product dropped, err_o set.
  - Last tag valid with mul_valid_i=0: err_o set, no res_valid_o.
  - err_o clears only on reset.
- busy_o = mul_valid_o | OR(tag valid bits).
- End-to-end latency: an accept at edge T returns res_valid_o in cycle T+1+MULT_LATENCY (3 cycles at default).
- Boundary cases:
  - enable_i dropped mid-stream: no new grants; busy_o falls after the last in-flight op returns.
  - A single requester alone is granted every cycle.
  - rr_ptr wrap from N_REQ-1 goes to 0.
  - Reset mid-operation discards all in-flight tags. The multiplier shares rst_i, so no stale product returns.

Decomposition:
- Shared package fp_pkg holds:
  - fp_width(EXP_WIDTH, FRAC_WIDTH) function.
  - Field index constants for sign/exp/frac.
  - Typedef for the {valid, id} tag struct.
- Sub-module rr_arbiter (N parameter): inputs req, ptr, en; output one-hot grant.
- Top level holds the issue register, tag pipeline and return steering.

Test Plan:
- Single request: requester 2 sends a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> ready[2] same cycle. mul_valid_o next cycle. res_valid_o=4'b0100, res_fp_o=0x40400000 three cycles after accept.
- All four valid continuously from reset -> grants 0,1,2,3,0,… one per cycle. Each result strobe matches its issuer in order. No err_o.
- Fairness: requesters 1 and 3 always valid, rr_ptr=2 -> grant order 3,1,3,1. Requesters 0 and 2 never get ready.
- enable_i=0 while requests pending -> req_ready_o=0. In-flight results still return, busy_o drops after MULT_LATENCY+1 cycles. Re-enable resumes from the saved rr_ptr.
- Spurious mul_valid_i with no tag -> res_valid_o=0 and err_o=1 the next cycle and stays 1. rst_i clears it asynchronously.
- Assert rst_i with 2 ops in flight -> all outputs 0 immediately. After release, no res_valid_o and no err_o.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP multiplier scheduler: format helpers, field indices, tag type.
package fp_pkg;

  localparam int unsigned DefaultExpWidth  = 8;
  localparam int unsigned DefaultFracWidth = 23;

  // Field positions for the default single-precision layout {sign, exp, frac}.
  localparam int unsigned FracLsb = 0;
  localparam int unsigned ExpLsb  = DefaultFracWidth;
  localparam int unsigned SignBit = DefaultExpWidth + DefaultFracWidth;

  // Tag ids are stored at a fixed width so the struct can live here; supports N_REQ <= 256.
  localparam int unsigned MaxIdWidth = 8;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
  } tag_t;

  function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned frac_w);
    return 1 + exp_w + frac_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  input  logic           en_i,
  output logic [N-1:0]   gnt_o
);

  logic        found;
  logic [31:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && req_i[idx[IdW-1:0]]) begin
        gnt_o[idx[IdW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mult_scheduler.sv
// Shares one pipelined FP multiplier among N_REQ requesters; tags each op with its issuer id
// and steers the returning product back to that requester.
module fp_mult_scheduler
  import fp_pkg::*;
#(
  parameter int unsigned EXP_WIDTH    = 8,
  parameter int unsigned FRAC_WIDTH   = 23,
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MULT_LATENCY = 2,
  localparam int unsigned FP_WIDTH    = fp_width(EXP_WIDTH, FRAC_WIDTH),
  localparam int unsigned ID_WIDTH    = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*FP_WIDTH-1:0] req_a_i,
  input  logic [N_REQ*FP_WIDTH-1:0] req_b_i,
  output logic [FP_WIDTH-1:0]       mul_a_o,
  output logic [FP_WIDTH-1:0]       mul_b_o,
  output logic                      mul_valid_o,
  input  logic [FP_WIDTH-1:0]       mul_fp_i,
  input  logic                      mul_valid_i,
  output logic [N_REQ-1:0]          res_valid_o,
  output logic [FP_WIDTH-1:0]       res_fp_o,
  output logic                      busy_o,
  output logic                      err_o
);

  logic [N_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                accept;

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] issue_id_q;
  logic [FP_WIDTH-1:0] mul_a_q, mul_b_q;
  logic                mul_valid_q;
  tag_t                tag_q [MULT_LATENCY];
  tag_t                last_tag;
  logic                tags_busy;
  logic                hit;
  logic                err_q;

  rr_arbiter #(
    .N   (N_REQ),
    .IdW (ID_WIDTH)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .en_i  (enable_i),
    .gnt_o (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) gnt_idx = ID_WIDTH'(i);
    end
  end

  assign accept   = |grant;
  assign rr_ptr_d = (gnt_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Ready is gated so the handshake is quiet for the whole reset interval.
  assign req_ready_o = rst_i ? '0 : grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      issue_id_q  <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        mul_a_q    <= req_a_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
        mul_b_q    <= req_b_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
        issue_id_q <= gnt_idx;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < MULT_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: mul_valid_q, id: MaxIdWidth'(issue_id_q)};
      for (int unsigned s = 1; s < MULT_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign last_tag = tag_q[MULT_LATENCY-1];

  always_comb begin
    tags_busy = 1'b0;
    for (int unsigned s = 0; s < MULT_LATENCY; s++) begin
      tags_busy = tags_busy | tag_q[s].valid;
    end
  end

  assign hit         = mul_valid_i & last_tag.valid & ~rst_i;
  assign res_valid_o = hit ? (N_REQ'(1) << last_tag.id) : '0;
  assign res_fp_o    = hit ? mul_fp_i : '0;

  // Any disagreement between the tag pipe and the multiplier's valid is a protocol error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (mul_valid_i != last_tag.valid) begin
      err_q <= 1'b1;
    end
  end

  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_valid_o = mul_valid_q;
  assign busy_o      = mul_valid_q | tags_busy;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fp_mult_scheduler.sv
// Directed bench for fp_mult_scheduler with a two-stage stub multiplier sharing rst_i.
module tb_fp_mult_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic [3:0]   req_valid_i;
  logic [3:0]   req_ready_o;
  logic [127:0] req_a_i, req_b_i;
  logic [31:0]  mul_a_o, mul_b_o, mul_fp_i, res_fp_o;
  logic         mul_valid_o, mul_valid_i, busy_o, err_o;
  logic [3:0]   res_valid_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] a_d [4];
  logic [31:0] b_d [4];
  logic [3:0]  hv  [3];
  logic [31:0] hd  [3];
  logic        exp_err;
  logic        spur;

  logic        m_v0, m_v1;
  logic [31:0] m_d0, m_d1;

  always #5 clk_i = ~clk_i;

  fp_mult_scheduler dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_valid_o (mul_valid_o),
    .mul_fp_i    (mul_fp_i),
    .mul_valid_i (mul_valid_i),
    .res_valid_o (res_valid_o),
    .res_fp_o    (res_fp_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  // Stub multiplier: exact for the 1.5*2.0 vector, otherwise a recognisable a^b pattern.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ b;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_v0 <= 1'b0; m_v1 <= 1'b0; m_d0 <= '0; m_d1 <= '0;
    end else begin
      m_v0 <= mul_valid_o;
      m_d0 <= fmul(mul_a_o, mul_b_o);
      m_v1 <= m_v0;
      m_d1 <= m_d0;
    end
  end

  assign mul_valid_i = m_v1 | spur;
  assign mul_fp_i    = m_d1;

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 128'(req_ready_o), 0);
    chk({tag, "_mul_valid"}, 128'(mul_valid_o), 0);
    chk({tag, "_mul_a"}, 128'(mul_a_o), 0);
    chk({tag, "_mul_b"}, 128'(mul_b_o), 0);
    chk({tag, "_res_valid"}, 128'(res_valid_o), 0);
    chk({tag, "_res_fp"}, 128'(res_fp_o), 0);
    chk({tag, "_busy"}, 128'(busy_o), 0);
    chk({tag, "_err"}, 128'(err_o), 0);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) begin
      hv[i] = '0;
      hd[i] = '0;
    end
  endtask

  // One cycle: drive at negedge, check 1ns later, advance the expected-result history.
  task automatic cyc(input logic [3:0] v, input logic en, input logic [3:0] er);
    req_valid_i = v;
    enable_i    = en;
    #1;
    chk("ready", 128'(req_ready_o), 128'(er));
    chk("mul_valid", 128'(mul_valid_o), 128'(|hv[0]));
    if (|hv[0]) begin
      chk("mul_a", 128'(mul_a_o), 128'(a_d[idx_of(hv[0])]));
      chk("mul_b", 128'(mul_b_o), 128'(b_d[idx_of(hv[0])]));
    end
    chk("res_valid", 128'(res_valid_o), 128'(hv[2]));
    chk("res_fp", 128'(res_fp_o), 128'(hd[2]));
    chk("busy", 128'(busy_o), 128'((|hv[0]) | (|hv[1]) | (|hv[2])));
    chk("err", 128'(err_o), 128'(exp_err));
    hv[2] = hv[1]; hd[2] = hd[1];
    hv[1] = hv[0]; hd[1] = hd[0];
    hv[0] = er;
    hd[0] = (|er) ? fmul(a_d[idx_of(er)], b_d[idx_of(er)]) : 32'h0;
    @(negedge clk_i);
  endtask

  initial begin
    a_d[0] = 32'h3F80_0000; b_d[0] = 32'h0000_00A5;
    a_d[1] = 32'h4120_0000; b_d[1] = 32'h0000_5A00;
    a_d[2] = 32'h3FC0_0000; b_d[2] = 32'h4000_0000;
    a_d[3] = 32'hC2C8_0000; b_d[3] = 32'h00F0_0000;
    for (int i = 0; i < 4; i++) begin
      req_a_i[i*32 +: 32] = a_d[i];
      req_b_i[i*32 +: 32] = b_d[i];
    end
    rst_i = 1'b1; enable_i = 1'b1; req_valid_i = 4'b1111; spur = 1'b0; exp_err = 1'b0;
    clear_hist();
    @(negedge clk_i);
    @(negedge clk_i);
    chk_zero("reset");
    rst_i = 1'b0;

    // Single request from requester 2: 1.5 * 2.0 = 3.0 returns three cycles later.
    cyc(4'b0100, 1'b1, 4'b0100);
    repeat (4) cyc(4'b0000, 1'b1, 4'b0000);

    // Reset pulse so the all-valid stream starts from rr_ptr = 0.
    rst_i = 1'b1;
    #1;
    chk_zero("reset_pulse");
    @(negedge clk_i);
    rst_i = 1'b0;
    clear_hist();

    for (int k = 0; k < 8; k++) cyc(4'b1111, 1'b1, 4'b0001 << (k % 4));

    // Move rr_ptr to 2, then 1 and 3 contend: 3,1,3,1.
    cyc(4'b0010, 1'b1, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b1000);
    cyc(4'b1010, 1'b1, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b1000);
    cyc(4'b1010, 1'b1, 4'b0010);

    // Enable drop with ops in flight; resume from the saved pointer (0).
    cyc(4'b1111, 1'b1, 4'b0100);
    cyc(4'b1111, 1'b1, 4'b1000);
    repeat (5) cyc(4'b1111, 1'b0, 4'b0000);
    cyc(4'b1111, 1'b1, 4'b0001);
    repeat (4) cyc(4'b0000, 1'b1, 4'b0000);

    // Spurious product with no tag: dropped, sticky error, cleared by async reset.
    spur = 1'b1;
    cyc(4'b0000, 1'b1, 4'b0000);
    spur    = 1'b0;
    exp_err = 1'b1;
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);
    #2;
    rst_i = 1'b1;
    #1;
    chk_zero("async_rst_err");
    @(negedge clk_i);
    clear_hist();
    exp_err = 1'b0;
    rst_i   = 1'b0;

    // Reset with two ops in flight: everything drops at once, nothing returns afterwards.
    cyc(4'b0011, 1'b1, 4'b0001);
    cyc(4'b0011, 1'b1, 4'b0010);
    #2;
    rst_i = 1'b1;
    #1;
    chk_zero("rst_midop");
    @(negedge clk_i);
    rst_i       = 1'b0;
    req_valid_i = 4'b0000;
    clear_hist();
    repeat (4) cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b1010, 1'b1, 4'b0010);
    repeat (4) cyc(4'b0000, 1'b1, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
